// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcode constants, FSM state and owner types for spi_ram_arbiter
package spi_ram_pkg;

   // SPI command opcodes carried in rx_data[DATA_WIDTH+1:DATA_WIDTH]
   localparam logic [1:0] OP_LD_WADDR = 2'b00;
   localparam logic [1:0] OP_WRITE    = 2'b01;
   localparam logic [1:0] OP_LD_RADDR = 2'b10;
   localparam logic [1:0] OP_READ     = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      OWN_SPI  = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester arbiter (SPI/host), round-robin or SPI priority via SPI_RAM_ARB_SPI_PRIO_EN
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_spi,
   input  logic req_host,
   input  logic advance,
   output logic gnt_spi,
   output logic gnt_host
);

   // Winner of the most recent contended decision; reset to host so SPI wins the first tie.
   owner_e last_q;
   owner_e last_d;

`ifdef SPI_RAM_ARB_SPI_PRIO_EN
   assign gnt_spi  = req_spi;
`else
   assign gnt_spi  = req_spi & (~req_host | (last_q == OWN_HOST));
`endif
   assign gnt_host = req_host & ~gnt_spi;

   // Only a real tie moves the pointer; an uncontested grant leaves the turn order alone.
   always_comb begin
      last_d = last_q;
      if (advance && req_spi && req_host) begin
         last_d = gnt_spi ? OWN_SPI : OWN_HOST;
      end
   end

   // Last-served register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= OWN_HOST;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - single-port RAM shared by SPI command stream and host; option SPI_RAM_ARB_SPI_PRIO_EN
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH+1:0]   rx_data,
   input  logic                    rx_valid,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_valid,
   input  logic                    host_req,
   input  logic                    host_we,
   input  logic [ADDR_WIDTH-1:0]   host_addr,
   input  logic [DATA_WIDTH-1:0]   host_wdata,
   output logic                    host_ack,
   output logic [DATA_WIDTH-1:0]   host_rdata,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    spi_ovf
);

   logic [1:0]            rx_op;
   logic [DATA_WIDTH-1:0] rx_payload;
   logic [ADDR_WIDTH-1:0] rx_addr;

   assign rx_op      = rx_data[DATA_WIDTH+1:DATA_WIDTH];
   assign rx_payload = rx_data[DATA_WIDTH-1:0];
   assign rx_addr    = rx_payload[ADDR_WIDTH-1:0];

   // SPI front end: address registers, one-entry pending command, overflow flag
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic                  pend_valid_q, pend_valid_d;
   logic                  pend_we_q, pend_we_d;
   logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
   logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic                  spi_ovf_q, spi_ovf_d;

   // Access engine: FSM, owner and latched request fields, response registers
   state_e                state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  acc_we_q, acc_we_d;
   logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_WIDTH-1:0] acc_wdata_q, acc_wdata_d;
   logic                  host_ack_q, host_ack_d;
   logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

   logic in_idle;
   logic host_elig;
   logic gnt_spi, gnt_host;
   logic take_spi, take_host;

   assign in_idle   = (state_q == ST_IDLE);
   // A held request is still high during its ack cycle; masking it avoids serving it twice.
   assign host_elig = host_req & ~host_ack_q;

   rr_arb2 u_arb (
      .clk      (CLK),
      .rst_n    (rst_n),
      .req_spi  (pend_valid_q),
      .req_host (host_elig),
      .advance  (in_idle),
      .gnt_spi  (gnt_spi),
      .gnt_host (gnt_host)
   );

   assign take_spi  = in_idle & gnt_spi;
   assign take_host = in_idle & gnt_host;

   // Decode SPI commands; address loads apply immediately, accesses queue in the pending slot
   always_comb begin
      waddr_d      = waddr_q;
      raddr_d      = raddr_q;
      pend_valid_d = pend_valid_q;
      pend_we_d    = pend_we_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      spi_ovf_d    = spi_ovf_q;
      if (take_spi) begin
         pend_valid_d = 1'b0;
      end
      if (rx_valid) begin
         case (rx_op)
            OP_LD_WADDR: waddr_d = rx_addr;
            OP_LD_RADDR: raddr_d = rx_addr;
            default: begin
               // The slot frees on the same edge it is granted, so a command arriving then still fits.
               if (!pend_valid_q || take_spi) begin
                  pend_valid_d = 1'b1;
                  pend_we_d    = (rx_op == OP_WRITE);
                  pend_addr_d  = (rx_op == OP_WRITE) ? waddr_q : raddr_q;
                  pend_data_d  = rx_payload;
               end else begin
                  spi_ovf_d = 1'b1;
               end
            end
         endcase
      end
   end

   // FSM next state and response generation
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      acc_we_d     = acc_we_q;
      acc_addr_d   = acc_addr_q;
      acc_wdata_d  = acc_wdata_q;
      host_ack_d   = 1'b0;
      host_rdata_d = host_rdata_q;
      tx_valid_d   = 1'b0;
      tx_data_d    = tx_data_q;
      case (state_q)
         ST_IDLE: begin
            if (take_spi) begin
               owner_d     = OWN_SPI;
               acc_we_d    = pend_we_q;
               acc_addr_d  = pend_addr_q;
               acc_wdata_d = pend_data_q;
               state_d     = ST_ACC;
            end else if (take_host) begin
               owner_d     = OWN_HOST;
               acc_we_d    = host_we;
               acc_addr_d  = host_addr;
               acc_wdata_d = host_wdata;
               state_d     = ST_ACC;
            end
         end
         ST_ACC: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            if (owner_q == OWN_HOST) begin
               host_ack_d = 1'b1;
               if (!acc_we_q) begin
                  host_rdata_d = mem_rdata;
               end
            end else if (!acc_we_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = mem_rdata;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any access in flight
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         waddr_q      <= '0;
         raddr_q      <= '0;
         pend_valid_q <= 1'b0;
         pend_we_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         spi_ovf_q    <= 1'b0;
         state_q      <= ST_IDLE;
         owner_q      <= OWN_SPI;
         acc_we_q     <= 1'b0;
         acc_addr_q   <= '0;
         acc_wdata_q  <= '0;
         host_ack_q   <= 1'b0;
         host_rdata_q <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
      end else begin
         waddr_q      <= waddr_d;
         raddr_q      <= raddr_d;
         pend_valid_q <= pend_valid_d;
         pend_we_q    <= pend_we_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         spi_ovf_q    <= spi_ovf_d;
         state_q      <= state_d;
         owner_q      <= owner_d;
         acc_we_q     <= acc_we_d;
         acc_addr_q   <= acc_addr_d;
         acc_wdata_q  <= acc_wdata_d;
         host_ack_q   <= host_ack_d;
         host_rdata_q <= host_rdata_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
      end
   end

   assign mem_en     = (state_q == ST_ACC);
   assign mem_we     = mem_en & acc_we_q;
   assign mem_addr   = acc_addr_q;
   assign mem_wdata  = acc_wdata_q;
   assign host_ack   = host_ack_q;
   assign host_rdata = host_rdata_q;
   assign tx_valid   = tx_valid_q;
   assign tx_data    = tx_data_q;
   assign spi_ovf    = spi_ovf_q;

endmodule
